// File: rtl/acs_survivor_unit.sv
// acs_survivor_unit
//   Add-compare-select and register-exchange survivor stage of the 4-state
//   (K=3, rate 1/2, generators 7/5) hard-decision Viterbi decoder.
//   State s = {u[t-1], u[t-2]}; input u moves the encoder to {u, u[t-1]}.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      single-cycle frame restart (metrics, survivors, fill count)
//   in_valid   sym is valid this cycle (always accepted)
//   sym        received hard symbol, sym[1] = c0 (g=7), sym[0] = c1 (g=5)
//   p0..p3     survivor words of states 0..3, bit 2 oldest, bit 0 newest
//   control    index of the state with the minimum metric
//   out_valid  p*/control were updated this cycle
//   dec_bit    bit 2 of the survivor selected by control
//   dec_valid  dec_bit is meaningful (survivor depth filled)
module acs_survivor_unit #(
  parameter int unsigned PM_W    = 6,
  parameter int unsigned PM_INIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [1:0] sym,
  output logic [2:0] p0,
  output logic [2:0] p1,
  output logic [2:0] p2,
  output logic [2:0] p3,
  output logic [1:0] control,
  output logic       out_valid,
  output logic       dec_bit,
  output logic       dec_valid
);

  localparam logic [PM_W-1:0] INIT_PM = PM_INIT[PM_W-1:0];
  localparam logic [PM_W:0]   PM_MAX  = {1'b0, {PM_W{1'b1}}};

  typedef enum logic {FILL, STEADY} state_t;

  state_t          state;
  logic [1:0]      fill_cnt;
  logic [PM_W-1:0] pm   [4];
  logic [2:0]      surv [4];

  logic [PM_W-1:0] src_pm   [4];
  logic [2:0]      src_surv [4];
  logic [PM_W:0]   cand0    [4];
  logic [PM_W:0]   cand1    [4];
  logic [PM_W:0]   new_pm   [4];
  logic [2:0]      new_surv [4];
  logic [PM_W-1:0] norm_pm  [4];
  logic [PM_W:0]   min_pm;
  logic [1:0]      best;
  logic [1:0]      cnt_next;

  // Hamming distance between the received symbol and the encoder output
  // for input u leaving state {u1, u2}.
  function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                               input logic u,
                                               input logic u1,
                                               input logic u2);
    logic [1:0] d;
    d = rx ^ {u ^ u1 ^ u2, u ^ u2};
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  always_comb begin
    logic [1:0]    nb;
    logic [1:0]    pa;
    logic [1:0]    pb;
    logic [PM_W:0] diff;

    // A start coinciding with in_valid feeds the initial values to the ACS.
    for (int unsigned i = 0; i < 4; i++) begin
      src_pm[i]   = start ? ((i == 0) ? '0 : INIT_PM) : pm[i];
      src_surv[i] = start ? 3'b000 : surv[i];
    end

    // Next state n = {u, a}; predecessors {a,0} and {a,1}; tie keeps {a,0}.
    for (int unsigned n = 0; n < 4; n++) begin
      nb = n[1:0];
      pa = {nb[0], 1'b0};
      pb = {nb[0], 1'b1};
      cand0[n] = {1'b0, src_pm[pa]} +
                 {{(PM_W-1){1'b0}}, branch_metric(sym, nb[1], nb[0], 1'b0)};
      cand1[n] = {1'b0, src_pm[pb]} +
                 {{(PM_W-1){1'b0}}, branch_metric(sym, nb[1], nb[0], 1'b1)};
      if (cand1[n] < cand0[n]) begin
        new_pm[n]   = cand1[n];
        new_surv[n] = {src_surv[pb][1:0], nb[1]};
      end else begin
        new_pm[n]   = cand0[n];
        new_surv[n] = {src_surv[pa][1:0], nb[1]};
      end
    end

    // Strict compare: lowest index wins on equal metrics.
    best   = '0;
    min_pm = new_pm[0];
    for (int unsigned i = 1; i < 4; i++) begin
      if (new_pm[i] < min_pm) begin
        min_pm = new_pm[i];
        best   = i[1:0];
      end
    end

    for (int unsigned i = 0; i < 4; i++) begin
      diff       = new_pm[i] - min_pm;
      norm_pm[i] = (diff > PM_MAX) ? PM_MAX[PM_W-1:0] : diff[PM_W-1:0];
    end

    if (start)
      cnt_next = 2'd1;
    else if (fill_cnt == 2'd3)
      cnt_next = 2'd3;
    else
      cnt_next = fill_cnt + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        pm[i]   <= (i == 0) ? '0 : INIT_PM;
        surv[i] <= '0;
      end
      state     <= FILL;
      fill_cnt  <= '0;
      control   <= '0;
      out_valid <= 1'b0;
      dec_bit   <= 1'b0;
      dec_valid <= 1'b0;
    end else if (in_valid) begin
      for (int unsigned i = 0; i < 4; i++) begin
        pm[i]   <= norm_pm[i];
        surv[i] <= new_surv[i];
      end
      fill_cnt  <= cnt_next;
      state     <= (cnt_next == 2'd3) ? STEADY : FILL;
      control   <= best;
      out_valid <= 1'b1;
      dec_bit   <= new_surv[best][2];
      // A restarting frame is never decided, even if the old one was steady.
      dec_valid <= (cnt_next == 2'd3) || ((state == STEADY) && !start);
    end else if (start) begin
      for (int unsigned i = 0; i < 4; i++) begin
        pm[i]   <= (i == 0) ? '0 : INIT_PM;
        surv[i] <= '0;
      end
      state     <= FILL;
      fill_cnt  <= '0;
      control   <= '0;
      out_valid <= 1'b0;
      dec_bit   <= 1'b0;
      dec_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      dec_valid <= 1'b0;
    end
  end

  assign p0 = surv[0];
  assign p1 = surv[1];
  assign p2 = surv[2];
  assign p3 = surv[3];

endmodule

// File: tb/tb_acs_survivor_unit.sv
module tb_acs_survivor_unit;

  localparam int PM_W    = 6;
  localparam int PM_INIT = 4;
  localparam int PM_MAX  = (1 << PM_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [1:0] sym;
  logic [2:0] p0, p1, p2, p3;
  logic [1:0] control;
  logic       out_valid, dec_bit, dec_valid;

  logic [16:0] obs;
  assign obs = {out_valid, control, p0, p1, p2, p3, dec_valid, dec_bit};

  always #5 clk = ~clk;

  acs_survivor_unit #(.PM_W(PM_W), .PM_INIT(PM_INIT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .sym(sym),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .control(control),
    .out_valid(out_valid), .dec_bit(dec_bit), .dec_valid(dec_valid)
  );

  // Reference model: forward trellis enumeration from each source state.
  int          mpm [4];
  logic [2:0]  ms  [4];
  int          mcnt;
  logic [1:0]  mctl;
  logic        mov, mdv, mdb;
  logic [16:0] sbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [16:0] mpack();
    return {mov, mctl, ms[0], ms[1], ms[2], ms[3], mdv, mdb};
  endfunction

  task automatic model_reset();
    mpm  = '{0, PM_INIT, PM_INIT, PM_INIT};
    ms   = '{3'b000, 3'b000, 3'b000, 3'b000};
    mcnt = 0;
    mctl = 2'd0;
    mov  = 1'b0;
    mdv  = 1'b0;
    mdb  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] s, input logic st);
    int         spm [4];
    logic [2:0] ss  [4];
    int         npm [4];
    logic [2:0] nsv [4];
    int         mn, bi, u1, u2, nx, c0, c1, bm, d;
    if (v) begin
      if (st) begin
        spm = '{0, PM_INIT, PM_INIT, PM_INIT};
        ss  = '{3'b000, 3'b000, 3'b000, 3'b000};
      end else begin
        spm = mpm;
        ss  = ms;
      end
      npm = '{1000000, 1000000, 1000000, 1000000};
      nsv = '{3'b000, 3'b000, 3'b000, 3'b000};
      for (int s0 = 0; s0 < 4; s0++) begin
        for (int u = 0; u < 2; u++) begin
          u1 = (s0 >> 1) & 1;
          u2 = s0 & 1;
          nx = u * 2 + u1;
          c0 = u ^ u1 ^ u2;
          c1 = u ^ u2;
          bm = ((s[1] ? 1 : 0) != c0 ? 1 : 0) + ((s[0] ? 1 : 0) != c1 ? 1 : 0);
          if (spm[s0] + bm < npm[nx]) begin
            npm[nx] = spm[s0] + bm;
            nsv[nx] = {ss[s0][1:0], (u == 1)};
          end
        end
      end
      mn = npm[0];
      bi = 0;
      for (int i = 1; i < 4; i++) if (npm[i] < mn) begin mn = npm[i]; bi = i; end
      for (int i = 0; i < 4; i++) begin
        d = npm[i] - mn;
        mpm[i] = (d > PM_MAX) ? PM_MAX : d;
      end
      ms   = nsv;
      mctl = 2'(bi);
      mdb  = nsv[bi][2];
      mcnt = st ? 1 : ((mcnt < 3) ? mcnt + 1 : 3);
      mov  = 1'b1;
      mdv  = (mcnt == 3);
    end else if (st) begin
      model_reset();
    end else begin
      mov = 1'b0;
      mdv = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus, push the model's expectation, land at #1
  // after the sampling edge with inputs released.
  task automatic step(input logic v, input logic [1:0] s, input logic st);
    @(negedge clk);
    in_valid = v;
    sym      = s;
    start    = st;
    model_step(v, s, st);
    sbq.push_back(mpack());
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sbq.delete();
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; sym = 2'b00;
    #12;
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, 17'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, 2'b00, 1'b0);
    exp = sbq.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_zeros();
    logic [16:0] exp;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 2'b00, 1'b0);
      exp = sbq.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL zeros_sb[%0d]: got %h expected %h", k, obs, exp);
      end
      n_checks++;
      if ({out_valid, control, p0, dec_bit} !== {1'b1, 2'd0, 3'b000, 1'b0}) begin
        n_fail++;
        $display("FAIL zeros_ctl[%0d]: got ov=%b ctl=%0d p0=%b db=%b expected 1 0 000 0",
                 k, out_valid, control, p0, dec_bit);
      end
      n_checks++;
      if (dec_valid !== (k >= 2)) begin
        n_fail++;
        $display("FAIL zeros_dv[%0d]: got %b expected %b", k, dec_valid, (k >= 2));
      end
    end
  endtask

  task automatic test_known();
    logic [16:0] exp;
    logic [1:0]  ksym [3];
    logic [1:0]  kctl [3];
    logic [2:0]  kp   [3];
    logic [2:0]  got;
    ksym = '{2'b11, 2'b10, 2'b11};
    kctl = '{2'd2, 2'd1, 2'd0};
    kp   = '{3'b001, 3'b010, 3'b100};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ksym[k], 1'b0);
      exp = sbq.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL known_sb[%0d]: got %h expected %h", k, obs, exp);
      end
      got = (k == 0) ? p2 : (k == 1) ? p1 : p0;
      n_checks++;
      if ({control, got, dec_valid} !== {kctl[k], kp[k], (k == 2)}) begin
        n_fail++;
        $display("FAIL known_val[%0d]: got ctl=%0d p=%b dv=%b expected ctl=%0d p=%b dv=%b",
                 k, control, got, dec_valid, kctl[k], kp[k], (k == 2));
      end
    end
    n_checks++;
    if (dec_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL known_decbit: got %b expected 1", dec_bit);
    end
  endtask

  task automatic test_single_error();
    logic [16:0] exp;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, (k == 3) ? 2'b01 : 2'b00, 1'b0);
      exp = sbq.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL err_sb[%0d]: got %h expected %h", k, obs, exp);
      end
      n_checks++;
      if ({control, p0, dec_bit} !== {2'd0, 3'b000, 1'b0}) begin
        n_fail++;
        $display("FAIL err_ctl[%0d]: got ctl=%0d p0=%b db=%b expected 0 000 0",
                 k, control, p0, dec_bit);
      end
    end
  endtask

  task automatic test_gaps();
    logic [16:0] exp;
    logic        gv [5];
    logic [1:0]  gs [5];
    gv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    gs = '{2'b11, 2'(($urandom)), 2'(($urandom)), 2'b10, 2'b11};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(gv[k], gs[k], 1'b0);
      exp = sbq.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL gap_sb[%0d]: got %h expected %h", k, obs, exp);
      end
      if (k == 1 || k == 2) begin
        n_checks++;
        if ({out_valid, control, p2} !== {1'b0, 2'd2, 3'b001}) begin
          n_fail++;
          $display("FAIL gap_hold[%0d]: got ov=%b ctl=%0d p2=%b expected 0 2 001",
                   k, out_valid, control, p2);
        end
      end
    end
    n_checks++;
    if ({control, p0, dec_valid, dec_bit} !== {2'd0, 3'b100, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL gap_final: got ctl=%0d p0=%b dv=%b db=%b expected 0 100 1 1",
               control, p0, dec_valid, dec_bit);
    end
  endtask

  task automatic test_start();
    logic [16:0] exp;
    logic [1:0]  ksym [3];
    ksym = '{2'b11, 2'b10, 2'b11};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 2'b11, 1'b0);
      exp = sbq.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL start_pre[%0d]: got %h expected %h", k, obs, exp);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ksym[k], (k == 0));
      exp = sbq.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL start_sb[%0d]: got %h expected %h", k, obs, exp);
      end
      n_checks++;
      if (dec_valid !== (k == 2)) begin
        n_fail++;
        $display("FAIL start_dv[%0d]: got %b expected %b", k, dec_valid, (k == 2));
      end
    end
    n_checks++;
    if ({control, p0, dec_bit} !== {2'd0, 3'b100, 1'b1}) begin
      n_fail++;
      $display("FAIL start_final: got ctl=%0d p0=%b db=%b expected 0 100 1",
               control, p0, dec_bit);
    end
    // Start without a symbol: pure re-initialisation, no output pulse.
    step(1'b0, 2'b00, 1'b1);
    exp = sbq.pop_front();
    n_checks++;
    if (obs !== exp || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_alone: got %h expected %h", obs, exp);
    end
    step(1'b1, 2'b11, 1'b0);
    exp = sbq.pop_front();
    n_checks++;
    if (obs !== exp || {control, p2, dec_valid} !== {2'd2, 3'b001, 1'b0}) begin
      n_fail++;
      $display("FAIL start_alone_next: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] exp;
    logic [1:0]  ksym [3];
    logic [1:0]  kctl [3];
    ksym = '{2'b11, 2'b10, 2'b11};
    kctl = '{2'd2, 2'd1, 2'd0};
    apply_reset();
    step(1'b1, 2'b11, 1'b0);
    void'(sbq.pop_front());
    step(1'b1, 2'b10, 1'b0);
    void'(sbq.pop_front());
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 17'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h expected %h", obs, 17'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sbq.delete();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ksym[k], 1'b0);
      exp = sbq.pop_front();
      n_checks++;
      if (obs !== exp || control !== kctl[k]) begin
        n_fail++;
        $display("FAIL rst_mid_seq[%0d]: got %h ctl=%0d expected %h ctl=%0d",
                 k, obs, control, exp, kctl[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp;
    logic        v, st;
    apply_reset();
    for (int k = 0; k < 60; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 11) == 0);
      step(v, 2'($urandom), st);
      exp = sbq.pop_front();
      n_checks++;
      if (obs !== exp || out_valid !== v) begin
        n_fail++;
        $display("FAIL b2b_sb[%0d]: got %h expected %h (v=%b st=%b)", k, obs, exp, v, st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_known();
    test_single_error();
    test_gaps();
    test_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
